// File: rtl/interp_add1_seq_if.sv
// Port bundle between the adder-1 sequencer, its operand mux and the
// interpolation output buffer.
interface interp_add1_seq_if #(
    parameter int IN_WIDTH  = 17,
    parameter int OUT_WIDTH = 19,
    parameter int ACC_WIDTH = 22
);
    logic                        start;
    logic signed [IN_WIDTH-1:0]  E1;
    logic signed [IN_WIDTH-1:0]  E2;
    logic signed [IN_WIDTH-1:0]  E3;
    logic signed [OUT_WIDTH-1:0] add1_a;
    logic                        out_ready;

    logic [2:0]                  sel;
    logic signed [IN_WIDTH-1:0]  E2_q;
    logic signed [IN_WIDTH-1:0]  E3_q;
    logic signed [IN_WIDTH:0]    reg_2E;
    logic signed [OUT_WIDTH-1:0] reg_5E;
    logic signed [ACC_WIDTH-1:0] interp_out;
    logic                        out_valid;
    logic                        busy;
    logic                        done;

    // Master is the sequencer; slave is the surrounding mux/buffer environment.
    modport master (
        input  start, E1, E2, E3, add1_a, out_ready,
        output sel, E2_q, E3_q, reg_2E, reg_5E, interp_out, out_valid, busy, done
    );

    modport slave (
        output start, E1, E2, E3, add1_a, out_ready,
        input  sel, E2_q, E3_q, reg_2E, reg_5E, interp_out, out_valid, busy, done
    );
endinterface

// File: rtl/interp_add1_seq.sv
// Adder-1 sequencer: captures pilot estimates, walks the 7-code mux schedule
// and accumulates the returned operand into a valid/ready output stream.
module interp_add1_seq #(
    parameter int IN_WIDTH  = 17,
    parameter int OUT_WIDTH = 19,
    parameter int ACC_WIDTH = 22
) (
    input logic               clk,
    input logic               rst,
    interp_add1_seq_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int P5_W = IN_WIDTH + 3;
    localparam logic signed [P5_W-1:0] SAT_MAX = P5_W'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [P5_W-1:0] SAT_MIN = P5_W'(-(2 ** (OUT_WIDTH - 1)));

    state_t                      r_state;
    logic [2:0]                  r_step;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic signed [ACC_WIDTH-1:0] r_interp_out;
    logic signed [IN_WIDTH-1:0]  r_e2_q;
    logic signed [IN_WIDTH-1:0]  r_e3_q;
    logic signed [IN_WIDTH:0]    r_reg_2e;
    logic signed [OUT_WIDTH-1:0] r_reg_5e;
    logic                        r_out_valid;
    logic                        r_done;

    logic                        w_slot_free;
    logic [2:0]                  w_sel;
    logic signed [P5_W-1:0]      w_e1_ext;
    logic signed [P5_W-1:0]      w_5e_full;
    logic signed [OUT_WIDTH-1:0] w_5e_sat;
    logic signed [ACC_WIDTH-1:0] w_add_ext;
    logic signed [ACC_WIDTH-1:0] w_sum;

    function automatic logic [2:0] sched_code(input logic [2:0] step);
        case (step)
            3'd0:    sched_code = 3'b000;
            3'd1:    sched_code = 3'b001;
            3'd2:    sched_code = 3'b011;
            3'd3:    sched_code = 3'b010;
            3'd4:    sched_code = 3'b110;
            3'd5:    sched_code = 3'b100;
            3'd6:    sched_code = 3'b101;
            default: sched_code = 3'b111;
        endcase
    endfunction

    assign w_slot_free = !r_out_valid || bus.out_ready;
    assign w_sel       = (r_state == S_RUN) ? sched_code(r_step) : 3'b111;

    // 5*E1 as (E1<<2)+E1 with three guard bits so the sum cannot wrap before saturation.
    assign w_e1_ext  = {{3{bus.E1[IN_WIDTH-1]}}, bus.E1};
    assign w_5e_full = (w_e1_ext <<< 2) + w_e1_ext;

    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        w_5e_sat = w_5e_full[OUT_WIDTH-1:0];
        if (w_5e_full > SAT_MAX) begin
            w_5e_sat = SAT_MAX[OUT_WIDTH-1:0];
        end else if (w_5e_full < SAT_MIN) begin
            w_5e_sat = SAT_MIN[OUT_WIDTH-1:0];
        end
    end

    assign w_add_ext = {{(ACC_WIDTH - OUT_WIDTH){bus.add1_a[OUT_WIDTH-1]}}, bus.add1_a};
    assign w_sum     = r_acc + w_add_ext;

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_step       <= '0;
            r_acc        <= '0;
            r_interp_out <= '0;
            r_e2_q       <= '0;
            r_e3_q       <= '0;
            r_reg_2e     <= '0;
            r_reg_5e     <= '0;
            r_out_valid  <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // Accepted sample retires here unless RUN loads a new one below.
            if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_e2_q   <= bus.E2;
                        r_e3_q   <= bus.E3;
                        r_reg_2e <= -{bus.E2, 1'b0};
                        r_reg_5e <= w_5e_sat;
                        r_acc    <= '0;
                        r_step   <= '0;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_slot_free) begin
                        r_acc        <= w_sum;
                        r_interp_out <= w_sum;
                        r_out_valid  <= 1'b1;
                        if (r_step == 3'd6) begin
                            r_state <= S_DONE;
                        end else begin
                            r_step <= r_step + 3'd1;
                        end
                    end
                end
                S_DONE: begin
                    if (w_slot_free) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.sel        = w_sel;
    assign bus.E2_q       = r_e2_q;
    assign bus.E3_q       = r_e3_q;
    assign bus.reg_2E     = r_reg_2e;
    assign bus.reg_5E     = r_reg_5e;
    assign bus.interp_out = r_interp_out;
    assign bus.out_valid  = r_out_valid;
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.done       = r_done;

endmodule

// File: tb/tb_interp_add1_seq.sv
// Scoreboard bench for interp_add1_seq: the stimulus pushes expected sums,
// a negedge monitor pops one per accepted output beat.
module tb_interp_add1_seq;

    localparam int IN_WIDTH  = 17;
    localparam int OUT_WIDTH = 19;
    localparam int ACC_WIDTH = 22;

    logic clk;
    logic rst;

    interp_add1_seq_if #(
        .IN_WIDTH (IN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH),
        .ACC_WIDTH(ACC_WIDTH)
    ) bus ();

    interp_add1_seq #(
        .IN_WIDTH (IN_WIDTH),
        .OUT_WIDTH(OUT_WIDTH),
        .ACC_WIDTH(ACC_WIDTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int n_acc  = 0;
    int exp_q[$];
    int vals[7];
    logic [2:0] sched_exp[7] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operand mux stand-in: each schedule code returns the value for that step.
    always_comb begin
        bus.add1_a = '0;
        for (int i = 0; i < 7; i++) begin
            if (bus.sel == sched_exp[i]) bus.add1_a = OUT_WIDTH'(vals[i]);
        end
    end

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                n_acc++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_sample: got %0d expected none", $signed(bus.interp_out));
                end else begin
                    check("interp_out", int'($signed(bus.interp_out)), exp_q.pop_front());
                end
            end
        end
    end

    task automatic load_run(input int v[7], input int e[7]);
        vals = v;
        foreach (e[i]) exp_q.push_back(e[i]);
    endtask

    // Called just after a rising edge; returns just after the capture edge.
    task automatic do_start(input int e1, input int e2, input int e3);
        bus.start = 1'b1;
        bus.E1    = IN_WIDTH'(e1);
        bus.E2    = IN_WIDTH'(e2);
        bus.E3    = IN_WIDTH'(e3);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.E1    = IN_WIDTH'(12345);
        bus.E2    = IN_WIDTH'(-777);
        bus.E3    = IN_WIDTH'(4242);
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) seen = 1'b1;
        end
        check({tag, "_done"}, int'(seen), 1);
        check({tag, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        int v1[7]  = '{1, 2, 3, 4, 5, 6, 7};
        int e1[7]  = '{1, 3, 6, 10, 15, 21, 28};
        int v2[7]  = '{-5, 10, 0, -1, 100, -200, 7};
        int e2[7]  = '{-5, 5, 5, 4, 104, -96, -89};
        int vmax[7], emax[7], vmin[7], emin[7];
        int acc_before;

        for (int k = 0; k < 7; k++) begin
            vmax[k] = 262143;
            emax[k] = (k + 1) * 262143;
            vmin[k] = -262144;
            emin[k] = (k + 1) * -262144;
        end

        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.E1        = '0;
        bus.E2        = '0;
        bus.E3        = '0;
        bus.out_ready = 1'b1;
        vals          = '{0, 0, 0, 0, 0, 0, 0};
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_sel", int'(bus.sel), 7);
        check("rst_interp_out", int'($signed(bus.interp_out)), 0);
        check("rst_reg_5E", int'($signed(bus.reg_5E)), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic sequence: operands, schedule, latency and done timing.
        load_run(v1, e1);
        do_start(100, -3, 7);
        check("t1_reg_2E", int'($signed(bus.reg_2E)), 6);
        check("t1_reg_5E", int'($signed(bus.reg_5E)), 500);
        check("t1_E2_q", int'($signed(bus.E2_q)), -3);
        check("t1_E3_q", int'($signed(bus.E3_q)), 7);
        check("t1_busy", int'(bus.busy), 1);
        check("t1_valid_lat1", int'(bus.out_valid), 0);
        check("t1_sel0", int'(bus.sel), int'(sched_exp[0]));
        for (int k = 1; k < 7; k++) begin
            @(posedge clk);
            #1;
            check("t1_valid", int'(bus.out_valid), 1);
            check("t1_sel", int'(bus.sel), int'(sched_exp[k]));
        end
        @(posedge clk);
        #1;
        check("t1_sel_done_state", int'(bus.sel), 7);
        check("t1_valid7", int'(bus.out_valid), 1);
        check("t1_done_early", int'(bus.done), 0);
        @(posedge clk);
        #1;
        check("t1_done", int'(bus.done), 1);
        check("t1_valid_clear", int'(bus.out_valid), 0);
        check("t1_busy_clear", int'(bus.busy), 0);
        @(posedge clk);
        #1;
        check("t1_done_pulse", int'(bus.done), 0);
        check("t1_drained", exp_q.size(), 0);

        // 5*E1 saturation at both ends.
        load_run(v2, e2);
        do_start(-65536, 65535, 1);
        check("t2_reg_5E_neg", int'($signed(bus.reg_5E)), -262144);
        check("t2_reg_2E", int'($signed(bus.reg_2E)), -131070);
        wait_done("t2a");
        load_run(v2, e2);
        do_start(65535, 0, -1);
        check("t2_reg_5E_pos", int'($signed(bus.reg_5E)), 262143);
        check("t2_reg_2E_zero", int'($signed(bus.reg_2E)), 0);
        wait_done("t2b");

        // Accumulator extremes: no wrap over seven full-scale steps.
        load_run(vmax, emax);
        do_start(0, 0, 0);
        wait_done("t3_max");
        check("t3_final_max", int'($signed(bus.interp_out)), 1835001);
        load_run(vmin, emin);
        do_start(0, 0, 0);
        wait_done("t3_min");
        check("t3_final_min", int'($signed(bus.interp_out)), -1835008);

        // Backpressure after sample 2.
        acc_before = n_acc;
        load_run(v1, e1);
        do_start(1, 2, 3);
        repeat (2) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("t4_hold_out", int'($signed(bus.interp_out)), 3);
            check("t4_hold_sel", int'(bus.sel), 3);
            check("t4_hold_valid", int'(bus.out_valid), 1);
        end
        bus.out_ready = 1'b1;
        wait_done("t4");
        check("t4_count", n_acc - acc_before, 7);

        // start during RUN must not recapture.
        acc_before = n_acc;
        load_run(v1, e1);
        do_start(100, -3, 7);
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.E1    = IN_WIDTH'(-1000);
        bus.E2    = IN_WIDTH'(50);
        bus.E3    = IN_WIDTH'(-9);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("t5_E2_q", int'($signed(bus.E2_q)), -3);
        check("t5_E3_q", int'($signed(bus.E3_q)), 7);
        check("t5_reg_2E", int'($signed(bus.reg_2E)), 6);
        check("t5_reg_5E", int'($signed(bus.reg_5E)), 500);
        wait_done("t5");
        check("t5_count", n_acc - acc_before, 7);

        // Reset after sample 4, then a clean run.
        load_run(v1, e1);
        do_start(100, -3, 7);
        repeat (4) @(posedge clk);
        #1;
        check("t6_pre_out", int'($signed(bus.interp_out)), 10);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", int'(bus.out_valid), 0);
        check("t6_rst_busy", int'(bus.busy), 0);
        check("t6_rst_sel", int'(bus.sel), 7);
        check("t6_rst_out", int'($signed(bus.interp_out)), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("t6_no_done", int'(bus.done), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("t6_idle_done", int'(bus.done), 0);
        load_run(v1, e1);
        do_start(100, -3, 7);
        wait_done("t6");
        check("t6_final", int'($signed(bus.interp_out)), 28);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
